// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 byte responder with synchronized pins, RX/TX shift registers and a one-deep TX holding register
module spi_responder (
    input  logic       clk,
    input  logic       resetq,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       wr,
    input  logic [7:0] tx_data,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_sck_s;
    logic [1:0]  r_cs_s;
    logic [1:0]  r_mosi_s;
    logic [1:0]  r_init;
    logic        r_armed;
    logic [2:0]  r_cnt;
    logic [6:0]  r_rx_sh;
    logic [7:0]  r_tx;
    logic [7:0]  r_hold;
    logic [7:0]  r_rx;
    logic        r_valid;
    logic        r_busy;
    logic        r_ovr;
    logic        r_oe;

    logic        w_cs;
    logic        w_mosi;
    logic        w_rise;
    logic        w_fall;
    logic        w_start;
    logic        w_stop;
    logic        w_rx_step;
    logic        w_done;
    logic        w_tx_load;
    logic        w_tx_shift;

    assign w_cs   = r_cs_s[1];
    assign w_mosi = r_mosi_s[1];
    assign w_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_fall = ~r_sck_s[1] & r_sck_s[2];

    // Pin synchronizers; r_init/r_armed stop the reset-level cs_n from faking a falling edge after reset
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_sck_s  <= 3'b000;
            r_cs_s   <= 2'b11;
            r_mosi_s <= 2'b11;
            r_init   <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], sck};
            r_cs_s   <= {r_cs_s[0], cs_n};
            r_mosi_s <= {r_mosi_s[0], mosi};
            r_init   <= {r_init[0], 1'b1};
            r_armed  <= r_armed | (r_init[1] & w_cs);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetq) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_rx_step  = 1'b0;
        w_done     = 1'b0;
        w_tx_load  = 1'b0;
        w_tx_shift = 1'b0;
        if (r_state == S_IDLE) begin
            if (r_armed && !w_cs) begin
                w_next    = S_ACTIVE;
                w_start   = 1'b1;
                w_tx_load = 1'b1;
            end
        end else if (w_cs) begin
            w_next = S_IDLE;
            w_stop = 1'b1;
        end else begin
            w_rx_step  = w_rise;
            w_done     = w_rise && (r_cnt == 3'd7);
            w_tx_load  = w_fall && (r_cnt == 3'd0);
            w_tx_shift = w_fall && (r_cnt != 3'd0);
        end
    end

    // Shift registers, bit counter and output enable
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_cnt   <= 3'd0;
            r_rx_sh <= 7'd0;
            r_tx    <= 8'hFF;
            r_oe    <= 1'b0;
        end else begin
            r_oe <= (w_next == S_ACTIVE);
            if (w_stop) begin
                r_cnt <= 3'd0;
                r_tx  <= 8'hFF;
            end else begin
                if (w_rx_step) begin
                    r_rx_sh <= {r_rx_sh[5:0], w_mosi};
                    r_cnt   <= r_cnt + 3'd1;
                end
                if (w_tx_load)       r_tx <= r_busy ? r_hold : 8'hFF;
                else if (w_tx_shift) r_tx <= {r_tx[6:0], 1'b1};
            end
        end
    end

    // TX holding register; a write in a load cycle wins so the new byte is kept for the next load
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_hold <= 8'd0;
            r_busy <= 1'b0;
        end else if (wr) begin
            r_hold <= tx_data;
            r_busy <= 1'b1;
        end else if (w_tx_load) begin
            r_busy <= 1'b0;
        end
    end

    // Received byte, valid and overrun flags; a completing byte takes priority over a read
    always_ff @(posedge clk) begin
        if (!resetq) begin
            r_rx    <= 8'd0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (w_done) begin
            r_rx    <= {r_rx_sh, w_mosi};
            r_valid <= 1'b1;
            if (r_valid && !rd) r_ovr <= 1'b1;
        end else if (rd) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign miso    = r_tx[7];
    assign miso_oe = r_oe;
    assign rx_data = r_rx;
    assign valid   = r_valid;
    assign busy    = r_busy;
    assign overrun = r_ovr;

endmodule
